// File: rtl/bbc_loader_pkg.sv
// Shared types and default constants for the BBC download loader.
package bbc_loader_pkg;

  // One buffered SDRAM write: absolute byte address plus data.
  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } loader_entry_t;

  localparam logic [24:0] ROM_BASE_DEF   = 25'h80000;
  localparam logic [24:0] ALT_BASE_DEF   = 25'h68000;
  localparam logic [7:0]  CMOS_INDEX_DEF = 8'hFF;

endpackage

// File: rtl/bbc_loader_fifo.sv
// Single-clock FIFO of loader entries. Pointers carry one extra wrap bit so
// full/empty/level fall out of a plain compare and subtract.
module bbc_loader_fifo
  import bbc_loader_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  loader_entry_t din,
  input  logic          pop,
  output loader_entry_t head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  loader_entry_t mem_q [DEPTH];
  loader_entry_t mem_d [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;
  // Head comes straight from the storage registers.
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointers and storage; requests against full/empty are ignored.
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset flushes the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/bbc_rom_loader.sv
// Buffers data_io download bytes and replays them into the SDRAM loader
// port one byte per memory slot; CMOS images go to the CMOS write port.
module bbc_rom_loader
  import bbc_loader_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [7:0]  ROM_INDEX  = 8'h00,
  parameter logic [24:0] ROM_BASE   = ROM_BASE_DEF,
  parameter logic [24:0] ALT_BASE   = ALT_BASE_DEF,
  parameter logic [7:0]  CMOS_INDEX = CMOS_INDEX_DEF,
  localparam int         LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic          mem_sync,
  output logic          loader_active,
  output logic          loader_we,
  output logic [24:0]   loader_addr,
  output logic [7:0]    loader_data,
  output logic          cmos_we,
  output logic [6:0]    cmos_addr,
  output logic [7:0]    cmos_di,
  output logic          overflow,
  output logic [LW-1:0] fifo_level
);

  loader_entry_t push_entry, head;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic          wr_ok, is_cmos, dl_rise;

  logic          download_q, download_d;
  logic          loader_we_q, loader_we_d;
  loader_entry_t issue_q, issue_d;
  logic          overflow_q, overflow_d;
  logic          cmos_we_q, cmos_we_d;
  logic [6:0]    cmos_addr_q, cmos_addr_d;
  logic [7:0]    cmos_di_q, cmos_di_d;

  bbc_loader_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_sys),
    .rst   (reset),
    .push  (fifo_push),
    .din   (push_entry),
    .pop   (fifo_pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Address mapping, push/pop qualification and all next-state logic.
  always_comb begin
    wr_ok   = ioctl_download & ioctl_wr;
    is_cmos = (ioctl_index == CMOS_INDEX);
    dl_rise = ioctl_download & ~download_q;

    // 25-bit add wraps naturally.
    push_entry.addr = ioctl_addr + ((ioctl_index == ROM_INDEX) ? ROM_BASE : ALT_BASE);
    push_entry.data = ioctl_dout;
    // A same-cycle pop does not make room: full is sampled pre-pop.
    fifo_push = wr_ok & ~is_cmos & ~fifo_full;
    // A same-cycle push is not visible: empty is sampled pre-push.
    fifo_pop  = mem_sync & ~fifo_empty;

    download_d  = ioctl_download;
    loader_we_d = loader_we_q;
    issue_d     = issue_q;
    if (mem_sync) begin
      loader_we_d = ~fifo_empty;
      if (!fifo_empty) issue_d = head;
    end

    // A drop on the rising-edge cycle still belongs to the new download.
    overflow_d = overflow_q;
    if (dl_rise) overflow_d = 1'b0;
    if (wr_ok && !is_cmos && fifo_full) overflow_d = 1'b1;

    cmos_we_d   = wr_ok & is_cmos;
    cmos_addr_d = cmos_addr_q;
    cmos_di_d   = cmos_di_q;
    if (cmos_we_d) begin
      cmos_addr_d = ioctl_addr[6:0];
      cmos_di_d   = ioctl_dout;
    end
  end

  // Slot issue, CMOS strobe, overflow and edge-detect registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      download_q  <= 1'b0;
      loader_we_q <= 1'b0;
      issue_q     <= '0;
      overflow_q  <= 1'b0;
      cmos_we_q   <= 1'b0;
      cmos_addr_q <= '0;
      cmos_di_q   <= '0;
    end else begin
      download_q  <= download_d;
      loader_we_q <= loader_we_d;
      issue_q     <= issue_d;
      overflow_q  <= overflow_d;
      cmos_we_q   <= cmos_we_d;
      cmos_addr_q <= cmos_addr_d;
      cmos_di_q   <= cmos_di_d;
    end
  end

  assign loader_we     = loader_we_q;
  assign loader_addr   = issue_q.addr;
  assign loader_data   = issue_q.data;
  assign overflow      = overflow_q;
  assign cmos_we       = cmos_we_q;
  assign cmos_addr     = cmos_addr_q;
  assign cmos_di       = cmos_di_q;
  assign loader_active = ioctl_download | (fifo_level != '0) | loader_we_q;

endmodule
